// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: opcodes, ALUOp encodings, the control
// bundle carried down the pipe and the ID/EX register action select.
package riscv_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic [1:0] alu_op;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = ctrl_t'(8'h00);

    typedef enum logic [1:0] {
        ACT_LOAD   = 2'b00,
        ACT_HOLD   = 2'b01,
        ACT_BUBBLE = 2'b10
    } idex_act_t;

    // A control bundle that does not belong to a real instruction is a NOP.
    function automatic ctrl_t ctrl_gate(input ctrl_t c, input logic valid);
        if (valid) begin
            return c;
        end else begin
            return CTRL_NOP;
        end
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination is
// read by the instruction in ID forces one bubble.
module load_use_detect (
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_reg_write,
    input  logic       id_mem_write,
    input  logic       id_branch,
    input  logic       id_mem_read,
    input  logic       id_alu_src,
    output logic       hazard
);

    logic uses_rs1_s;
    logic uses_rs2_s;
    logic load_in_ex_s;

    // rs2 is only a real source for stores, branches and register-register ALU ops
    assign uses_rs1_s   = id_reg_write | id_mem_write | id_branch | id_mem_read;
    assign uses_rs2_s   = id_mem_write | id_branch | (id_reg_write & ~id_alu_src);
    assign load_in_ex_s = ex_valid & ex_mem_read & (ex_rd != 5'd0);

    assign hazard = load_in_ex_s & id_valid &
                    ((uses_rs1_s & (ex_rd == id_rs1)) |
                     (uses_rs2_s & (ex_rd == id_rs2)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// downstream hold and saturating bubble/flush performance counters.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7_b5,
    input  logic            id_branch,
    input  logic            id_mem_read,
    input  logic            id_mem_to_reg,
    input  logic            id_mem_write,
    input  logic            id_alu_src,
    input  logic            id_reg_write,
    input  logic [1:0]      id_alu_op,
    input  logic            flush,
    input  logic            ex_hold,
    output logic            stall_front,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7_b5,
    output logic            ex_branch,
    output logic            ex_mem_read,
    output logic            ex_mem_to_reg,
    output logic            ex_mem_write,
    output logic            ex_alu_src,
    output logic            ex_reg_write,
    output logic [1:0]      ex_alu_op,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic            funct7_b5;
    } data_t;

    localparam data_t DATA_ZERO = data_t'({$bits(data_t){1'b0}});

    data_t      id_data_s, nxt_data_s, ex_data_r;
    ctrl_t      id_ctrl_s, nxt_ctrl_s, ex_ctrl_r;
    logic       nxt_valid_s, ex_valid_r;
    logic       hazard_s, bubble_inc_s;
    idex_act_t  act_s;
    logic [CNT_W-1:0] bubble_cnt_r, flush_cnt_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    load_use_detect u_detect (
        .ex_valid     (ex_valid_r),
        .ex_mem_read  (ex_ctrl_r.mem_read),
        .ex_rd        (ex_data_r.rd),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_reg_write (id_reg_write),
        .id_mem_write (id_mem_write),
        .id_branch    (id_branch),
        .id_mem_read  (id_mem_read),
        .id_alu_src   (id_alu_src),
        .hazard       (hazard_s)
    );

    // Flush overrides everything, including a stall request, so the front end keeps fetching the target
    assign stall_front  = ~flush & (ex_hold | hazard_s);
    assign bubble_inc_s = (act_s == ACT_BUBBLE) & ~flush;

    // Select the register action and form the next ID/EX contents
    always_comb begin
        id_ctrl_s = '{branch: id_branch, mem_read: id_mem_read, mem_to_reg: id_mem_to_reg,
                      alu_op: id_alu_op, mem_write: id_mem_write, alu_src: id_alu_src,
                      reg_write: id_reg_write};
        id_data_s = '{pc: id_pc, rs1_data: id_rs1_data, rs2_data: id_rs2_data, imm: id_imm,
                      rs1: id_rs1, rs2: id_rs2, rd: id_rd, funct3: id_funct3,
                      funct7_b5: id_funct7_b5};
        if (flush) begin
            act_s = ACT_BUBBLE;
        end else if (ex_hold) begin
            act_s = ACT_HOLD;
        end else if (hazard_s) begin
            act_s = ACT_BUBBLE;
        end else begin
            act_s = ACT_LOAD;
        end
        nxt_valid_s = ex_valid_r;
        nxt_ctrl_s  = ex_ctrl_r;
        nxt_data_s  = ex_data_r;
        case (act_s)
            ACT_LOAD: begin
                nxt_valid_s = id_valid;
                nxt_ctrl_s  = ctrl_gate(id_ctrl_s, id_valid);
                nxt_data_s  = id_data_s;
            end
            ACT_HOLD: begin
                nxt_valid_s = ex_valid_r;
            end
            ACT_BUBBLE: begin
                nxt_valid_s = 1'b0;
                nxt_ctrl_s  = CTRL_NOP;
                nxt_data_s  = DATA_ZERO;
            end
            default: begin
                nxt_valid_s = 1'b0;
                nxt_ctrl_s  = CTRL_NOP;
                nxt_data_s  = DATA_ZERO;
            end
        endcase
    end

    // ID/EX register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_r <= 1'b0;
            ex_ctrl_r  <= CTRL_NOP;
            ex_data_r  <= DATA_ZERO;
        end else begin
            ex_valid_r <= nxt_valid_s;
            ex_ctrl_r  <= nxt_ctrl_s;
            ex_data_r  <= nxt_data_s;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            if (bubble_inc_s) begin
                bubble_cnt_r <= sat_inc(bubble_cnt_r);
            end
            if (flush) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end
        end
    end

    assign ex_valid      = ex_valid_r;
    assign ex_pc         = ex_data_r.pc;
    assign ex_rs1_data   = ex_data_r.rs1_data;
    assign ex_rs2_data   = ex_data_r.rs2_data;
    assign ex_imm        = ex_data_r.imm;
    assign ex_rs1        = ex_data_r.rs1;
    assign ex_rs2        = ex_data_r.rs2;
    assign ex_rd         = ex_data_r.rd;
    assign ex_funct3     = ex_data_r.funct3;
    assign ex_funct7_b5  = ex_data_r.funct7_b5;
    assign ex_branch     = ex_ctrl_r.branch;
    assign ex_mem_read   = ex_ctrl_r.mem_read;
    assign ex_mem_to_reg = ex_ctrl_r.mem_to_reg;
    assign ex_mem_write  = ex_ctrl_r.mem_write;
    assign ex_alu_src    = ex_ctrl_r.alu_src;
    assign ex_reg_write  = ex_ctrl_r.reg_write;
    assign ex_alu_op     = ex_ctrl_r.alu_op;
    assign bubble_cnt    = bubble_cnt_r;
    assign flush_cnt     = flush_cnt_r;

endmodule
